// File: rtl/count_mon_pkg.sv
// Shared types for the count step monitor: observer states and per-cycle step classes.
package count_mon_pkg;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    ARMED = 3'd1,
    UP    = 3'd2,
    DN    = 3'd3,
    ERR   = 3'd4
  } mon_state_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STEP_UP = 2'd1,
    STEP_DN = 2'd2,
    ILLEGAL = 2'd3
  } step_cls_e;

  // Direction is only known while tracking a run of up or down steps.
  function automatic logic is_dir_state(input mon_state_e s);
    return (s == UP) || (s == DN);
  endfunction

endpackage

// File: rtl/count_step_classify.sv
// Combinational classifier of one count step (prev -> cur), including wrap detection.
module count_step_classify
  import count_mon_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cur,
  output step_cls_e        cls_c,
  output logic             wrap_up_c,
  output logic             wrap_dn_c
);

  logic [CNT_W-1:0] delta;

  assign delta = cur - prev;

  // With CNT_W=1 a delta of 1 is also all-ones; the UP test wins by ordering.
  always_comb begin
    cls_c = ILLEGAL;
    if (delta == CNT_W'(1)) begin
      cls_c = STEP_UP;
    end else if (delta == {CNT_W{1'b1}}) begin
      cls_c = STEP_DN;
    end else if (delta == '0) begin
      cls_c = HOLD;
    end
  end

  assign wrap_up_c = (cls_c == STEP_UP) && (prev == {CNT_W{1'b1}}) && (cur == '0);
  assign wrap_dn_c = (cls_c == STEP_DN) && (prev == '0) && (cur == {CNT_W{1'b1}});

endmodule

// File: rtl/count_step_monitor_fsm.sv
// Observer of an up/down counter: tracks direction, flags wraps, reversals and illegal steps.
module count_step_monitor_fsm
  import count_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = 3,
  parameter int unsigned WRAP_CNT_W = 8,
  parameter bit          ERR_STICKY = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [CNT_W-1:0]      count_in,
  output logic                  dir_valid,
  output logic                  dir_up,
  output logic                  wrap_up,
  output logic                  wrap_dn,
  output logic                  reversal,
  output logic                  step_err,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  mon_state_e            state_q;
  mon_state_e            state_d;
  logic [CNT_W-1:0]      prev_q;
  step_cls_e             cls_c;
  logic                  wrap_up_c;
  logic                  wrap_dn_c;
  logic                  wrap_up_d;
  logic                  wrap_dn_d;
  logic                  reversal_d;
  logic [WRAP_CNT_W-1:0] wrap_cnt_d;

  count_step_classify #(
    .CNT_W (CNT_W)
  ) u_classify (
    .prev      (prev_q),
    .cur       (count_in),
    .cls_c     (cls_c),
    .wrap_up_c (wrap_up_c),
    .wrap_dn_c (wrap_dn_c)
  );

  // Next state and next pulse/counter values.
  always_comb begin
    state_d    = state_q;
    wrap_up_d  = 1'b0;
    wrap_dn_d  = 1'b0;
    reversal_d = 1'b0;
    wrap_cnt_d = wrap_cnt;
    case (state_q)
      INIT: state_d = ARMED;
      ARMED, UP, DN: begin
        wrap_up_d = wrap_up_c;
        wrap_dn_d = wrap_dn_c;
        case (cls_c)
          STEP_UP: begin
            state_d    = UP;
            reversal_d = (state_q == DN);
          end
          STEP_DN: begin
            state_d    = DN;
            reversal_d = (state_q == UP);
          end
          ILLEGAL: state_d = ERR;
          default: state_d = state_q;
        endcase
      end
      ERR: begin
        if (!ERR_STICKY) begin
          state_d = ARMED;
        end
      end
      default: state_d = INIT;
    endcase
    if ((wrap_up_d || wrap_dn_d) && (wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
      wrap_cnt_d = wrap_cnt + WRAP_CNT_W'(1);
    end
  end

  // Clear has priority over any event sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= INIT;
      prev_q    <= '0;
      dir_valid <= 1'b0;
      dir_up    <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      reversal  <= 1'b0;
      step_err  <= 1'b0;
      wrap_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= count_in;
      dir_valid <= is_dir_state(state_d);
      dir_up    <= (state_d == UP);
      wrap_up   <= wrap_up_d;
      wrap_dn   <= wrap_dn_d;
      reversal  <= reversal_d;
      step_err  <= (state_d == ERR);
      wrap_cnt  <= wrap_cnt_d;
    end
  end

endmodule

// File: tb/tb_count_step_monitor_fsm.sv
// Randomized and directed bench for count_step_monitor_fsm across four parameter sets.
module tb_count_step_monitor_fsm;

  localparam int NI = 4;
  // Instances: 0 = (3,8,sticky), 1 = (3,8,non-sticky), 2 = (3,2,sticky), 3 = (1,8,sticky)
  localparam int CMOD[NI]   = '{8, 8, 8, 2};
  localparam int WMAX[NI]   = '{255, 255, 3, 255};
  localparam bit STICKY[NI] = '{1'b1, 1'b0, 1'b1, 1'b1};

  logic       clk;
  logic       rst;
  logic       clr;
  logic [2:0] count_in;
  logic [0:0] count_lsb;

  logic dv [NI];
  logic du [NI];
  logic wu [NI];
  logic wd [NI];
  logic rv [NI];
  logic se [NI];
  logic [7:0] wc0, wc1, wc3;
  logic [1:0] wc2;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 0;

  typedef struct {
    int prev;
    bit primed;
    int dir;
    bit err;
    int wraps;
    bit wu;
    bit wd;
    bit rv;
  } mstate_t;

  mstate_t m[NI];

  assign count_lsb = count_in[0:0];

  count_step_monitor_fsm #(.CNT_W(3), .WRAP_CNT_W(8), .ERR_STICKY(1'b1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .count_in(count_in),
    .dir_valid(dv[0]), .dir_up(du[0]), .wrap_up(wu[0]), .wrap_dn(wd[0]),
    .reversal(rv[0]), .step_err(se[0]), .wrap_cnt(wc0));

  count_step_monitor_fsm #(.CNT_W(3), .WRAP_CNT_W(8), .ERR_STICKY(1'b0)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .count_in(count_in),
    .dir_valid(dv[1]), .dir_up(du[1]), .wrap_up(wu[1]), .wrap_dn(wd[1]),
    .reversal(rv[1]), .step_err(se[1]), .wrap_cnt(wc1));

  count_step_monitor_fsm #(.CNT_W(3), .WRAP_CNT_W(2), .ERR_STICKY(1'b1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .count_in(count_in),
    .dir_valid(dv[2]), .dir_up(du[2]), .wrap_up(wu[2]), .wrap_dn(wd[2]),
    .reversal(rv[2]), .step_err(se[2]), .wrap_cnt(wc2));

  count_step_monitor_fsm #(.CNT_W(1), .WRAP_CNT_W(8), .ERR_STICKY(1'b1)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .count_in(count_lsb),
    .dir_valid(dv[3]), .dir_up(du[3]), .wrap_up(wu[3]), .wrap_dn(wd[3]),
    .reversal(rv[3]), .step_err(se[3]), .wrap_cnt(wc3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int act_wc(input int i);
    case (i)
      0: return int'(wc0);
      1: return int'(wc1);
      2: return int'(wc2);
      default: return int'(wc3);
    endcase
  endfunction

  task automatic chk(input string name, input int i, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s[u%0d] t=%0t actual=%0d required=%0d", name, i, $time, act, exp);
    end
  endtask

  // Reference: observe steps as modular differences and remember a direction sign.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      int c;
      int d;
      bit up;
      bit dn;
      c = int'(count_in) % CMOD[i];
      m[i].wu = 0;
      m[i].wd = 0;
      m[i].rv = 0;
      if (rst || clr) begin
        m[i] = '{default: 0};
      end else if (!m[i].primed) begin
        m[i].prev   = c;
        m[i].primed = 1;
      end else if (m[i].err) begin
        m[i].prev = c;
        if (!STICKY[i]) m[i].err = 0;
      end else begin
        d  = (c - m[i].prev + CMOD[i]) % CMOD[i];
        up = (d == 1);
        dn = !up && (d == CMOD[i] - 1);
        if (!up && !dn && d != 0) begin
          m[i].err = 1;
          m[i].dir = 0;
        end else begin
          m[i].wu = up && (m[i].prev == CMOD[i] - 1) && (c == 0);
          m[i].wd = dn && (m[i].prev == 0) && (c == CMOD[i] - 1);
          m[i].rv = (up && m[i].dir < 0) || (dn && m[i].dir > 0);
          if (up) m[i].dir = 1;
          if (dn) m[i].dir = -1;
          if ((m[i].wu || m[i].wd) && m[i].wraps < WMAX[i]) m[i].wraps++;
        end
        m[i].prev = c;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < NI; i++) begin
        chk("dir_valid", i, int'(dv[i]), int'(m[i].dir != 0 && !m[i].err));
        chk("dir_up",    i, int'(du[i]), int'(m[i].dir > 0 && !m[i].err));
        chk("wrap_up",   i, int'(wu[i]), int'(m[i].wu));
        chk("wrap_dn",   i, int'(wd[i]), int'(m[i].wd));
        chk("reversal",  i, int'(rv[i]), int'(m[i].rv));
        chk("step_err",  i, int'(se[i]), int'(m[i].err));
        chk("wrap_cnt",  i, act_wc(i),   m[i].wraps);
      end
    end
  end

  task automatic drive(input int v);
    count_in = 3'(v);
    @(negedge clk);
  endtask

  task automatic clear_and_load(input int v);
    clr = 1'b1;
    drive(v);
    clr = 1'b0;
    drive(v);
  endtask

  initial begin
    int cnt;
    int r;
    rst = 1'b1;
    clr = 1'b0;
    count_in = 3'd5;
    @(negedge clk);
    checking = 1;
    drive(5);
    chk("rst_dir_valid", 0, int'(dv[0]), 0);
    chk("rst_step_err", 0, int'(se[0]), 0);
    chk("rst_wrap_cnt", 0, int'(wc0), 0);
    rst = 1'b0;
    drive(5);
    drive(5);
    chk("armed_dir_valid", 0, int'(dv[0]), 0);

    // Count up through a wrap
    clear_and_load(0);
    for (int v = 1; v <= 7; v++) drive(v);
    chk("up_dir_up", 0, int'(du[0]), 1);
    drive(0);
    chk("lit_wrap_up", 0, int'(wu[0]), 1);
    chk("lit_wrap_cnt1", 0, int'(wc0), 1);
    drive(1);
    chk("lit_wrap_up_end", 0, int'(wu[0]), 0);
    chk("lit_no_rev", 0, int'(rv[0]), 0);

    // Reversals
    clear_and_load(3);
    drive(4);
    drive(5);
    drive(4);
    chk("lit_rev1", 0, int'(rv[0]), 1);
    chk("lit_rev1_dir", 0, int'(du[0]), 0);
    drive(3);
    chk("lit_rev_end", 0, int'(rv[0]), 0);
    drive(4);
    chk("lit_rev2", 0, int'(rv[0]), 1);

    // Down wrap
    clear_and_load(2);
    drive(1);
    drive(0);
    drive(7);
    chk("lit_wrap_dn", 0, int'(wd[0]), 1);
    chk("lit_wrap_dn_cnt", 0, int'(wc0), 1);
    drive(6);
    chk("lit_wrap_dn_end", 0, int'(wd[0]), 0);

    // Illegal step, sticky vs recovering
    clear_and_load(2);
    drive(5);
    chk("lit_err", 0, int'(se[0]), 1);
    chk("lit_err_dv", 0, int'(dv[0]), 0);
    drive(6);
    chk("lit_err_sticky", 0, int'(se[0]), 1);
    chk("lit_err_recover", 1, int'(se[1]), 0);
    drive(7);
    chk("lit_armed_up", 1, int'(dv[1]), 1);
    clr = 1'b1;
    drive(7);
    clr = 1'b0;
    chk("lit_err_clr", 0, int'(se[0]), 0);

    // Saturation, then clear colliding with a wrap step
    clear_and_load(0);
    for (int k = 0; k < 5; k++) for (int v = 1; v <= 8; v++) drive(v % 8);
    chk("lit_sat", 2, int'(wc2), 3);
    chk("lit_nosat", 0, int'(wc0), 5);
    for (int v = 1; v <= 7; v++) drive(v);
    clr = 1'b1;
    drive(0);
    clr = 1'b0;
    chk("lit_clr_wrap", 0, int'(wu[0]), 0);
    chk("lit_clr_cnt", 0, int'(wc0), 0);

    // Upstream up/down counter with occasional glitches, clears and resets
    cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) cnt = (cnt + 1) % 8;
      else if (r < 75) cnt = (cnt + 7) % 8;
      else if (r < 95) cnt = cnt;
      else cnt = int'($urandom_range(0, 7));
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      drive(cnt);
    end
    clr = 1'b0;
    rst = 1'b0;
    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
